scr_base_l3_bk_tp_rpl_q: RTL

L3 bank tag pipe replay queue: receiving end of the tag pipe D3 retry indication. Captures requests that D3 resolves as "retry" (resource conflict, set busy), holds them in an in-order FIFO, applies a programmable backoff, and re-injects them into the tag pipe D0 arbiter over a valid/ready handshake. Sits between the D3 stage output and the D0 replay input of the same bank.

---
 rtl/scr_base_l3_bk_tp_rpl_q.sv | 107 ++++++++++
 1 files changed

// File: rtl/scr_base_l3_bk_tp_rpl_q.sv
// L3 bank tag pipe replay queue: in-order FIFO of D3 retries re-offered to the D0 arbiter.
// Optional head backoff timer enabled by defining SCR_L3_BK_TP_RPL_BACKOFF_EN.
module scr_base_l3_bk_tp_rpl_q #(
  parameter int DEPTH = 4,
  parameter int REQ_W = 64
`ifdef SCR_L3_BK_TP_RPL_BACKOFF_EN
  , parameter int BACKOFF = 8
`endif
) (
  input  logic                       rst_n,
  input  logic                       clk,
  input  logic                       d3_rpl_vld,
  input  logic [REQ_W-1:0]           d3_rpl_req,
  output logic                       rpl_full,
  output logic                       d0_rpl_vld,
  output logic [REQ_W-1:0]           d0_rpl_req,
  input  logic                       d0_rpl_rdy,
  input  logic                       rpl_flush,
  output logic [$clog2(DEPTH+1)-1:0] rpl_cnt,
  output logic                       rpl_ovf_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [REQ_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic             pop;
  logic             push;
  logic             room;
  logic             wr_en;
  logic             head_rdy;

  assign pop   = d0_rpl_vld & d0_rpl_rdy;
  assign push  = d3_rpl_vld & ~rpl_flush;
  // A full queue still takes a push when the head leaves in the same cycle.
  assign room  = (cnt != CW'(DEPTH)) | pop;
  assign wr_en = push & room;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    cnt_nxt = cnt;
    if (rpl_flush)          cnt_nxt = '0;
    else if (wr_en && !pop) cnt_nxt = cnt + CW'(1);
    else if (pop && !wr_en) cnt_nxt = cnt - CW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cnt         <= '0;
      rpl_full    <= 1'b0;
      rpl_ovf_err <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      rpl_full <= (cnt_nxt == CW'(DEPTH));
      if (push && !room) rpl_ovf_err <= 1'b1;
      if (rpl_flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + AW'(1);
        if (pop)   rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // NOTE: the payload array is reset because the head payload must read zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= d3_rpl_req;
    end
  end

`ifdef SCR_L3_BK_TP_RPL_BACKOFF_EN
  logic [7:0] timer;
  logic [7:0] timer_nxt;

  // Reload on a new head: first write into an empty queue, or a pop that leaves entries.
  always_comb begin
    timer_nxt = (timer == 8'd0) ? 8'd0 : timer - 8'd1;
    if ((wr_en && cnt == '0) || (pop && cnt_nxt != '0)) timer_nxt = 8'(BACKOFF);
    if (rpl_flush) timer_nxt = 8'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) timer <= 8'd0;
    else        timer <= timer_nxt;
  end

  assign head_rdy = (timer == 8'd0);
`else
  assign head_rdy = 1'b1;
`endif

  assign d0_rpl_vld = (cnt != '0) & head_rdy;
  assign d0_rpl_req = mem[rd_ptr];
  assign rpl_cnt    = cnt;

endmodule
